// File: rtl/pc_select_reg.sv
// pc_select_reg: registered next-PC selector with stall hold, redirect
// override, a one-entry pending redirect buffer and a sticky illegal-select flag.
module pc_select_reg #(
    parameter int unsigned     WIDTH       = 32,
    parameter int unsigned     NUM_IN      = 4,
    parameter int unsigned     SEL_W       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clock_in,
    input  logic                    reset_n_in,
    input  logic [NUM_IN*WIDTH-1:0] value_in,
    input  logic [SEL_W-1:0]        select_in,
    input  logic                    stall_in,
    input  logic                    redirect_valid_in,
    input  logic [WIDTH-1:0]        redirect_value_in,
    output logic [WIDTH-1:0]        value_out,
    output logic                    redirect_pending_out,
    output logic                    select_error_out
);

    // Every encodable select value gets a slot; slots past NUM_IN read as zero
    // so the index below is always in range.
    localparam int unsigned NUM_SLOTS = 32'(1) << SEL_W;

    // Per-edge action, in priority order.
    typedef enum logic [2:0] {
        ACT_HOLD,       // stall without redirect
        ACT_CAPTURE,    // stall with redirect: buffer it
        ACT_REDIRECT,   // redirect wins over pending and select
        ACT_DRAIN,      // release the buffered redirect
        ACT_SELECT,     // normal candidate selection
        ACT_ILLEGAL     // out-of-range select: hold and flag
    } action_e;

    logic [WIDTH-1:0] cand_c [NUM_SLOTS];
    logic             sel_legal_c;
    action_e          action_c;

    logic [WIDTH-1:0] pend_value_q;
    logic [WIDTH-1:0] value_d;
    logic [WIDTH-1:0] pend_value_d;
    logic             pend_d;
    logic             err_d;

    // Unpack the candidate bus into fixed-offset slots.
    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_cand
        if (k < NUM_IN) begin : g_real
            assign cand_c[k] = value_in[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign cand_c[k] = '0;
        end
    end

    // Select is unsigned; the comparison is constant-true when every code is legal.
    assign sel_legal_c = (32'(select_in) < NUM_IN);

    // Priority decode; select_in is consulted only once stall, redirect and pending are all clear.
    always_comb begin
        action_c = ACT_HOLD;
        if (stall_in) begin
            action_c = redirect_valid_in ? ACT_CAPTURE : ACT_HOLD;
        end else if (redirect_valid_in) begin
            action_c = ACT_REDIRECT;
        end else if (redirect_pending_out) begin
            action_c = ACT_DRAIN;
        end else if (sel_legal_c) begin
            action_c = ACT_SELECT;
        end else begin
            action_c = ACT_ILLEGAL;
        end
    end

    // Next-state values for the output and pending registers.
    always_comb begin
        value_d      = value_out;
        pend_value_d = pend_value_q;
        pend_d       = redirect_pending_out;
        err_d        = select_error_out;
        unique case (action_c)
            ACT_HOLD: begin
            end
            ACT_CAPTURE: begin
                pend_value_d = redirect_value_in;
                pend_d       = 1'b1;
            end
            ACT_REDIRECT: begin
                value_d = redirect_value_in;
                pend_d  = 1'b0;
            end
            ACT_DRAIN: begin
                value_d = pend_value_q;
                pend_d  = 1'b0;
            end
            ACT_SELECT: begin
                value_d = cand_c[select_in];
            end
            ACT_ILLEGAL: begin
                err_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State registers; reset discards any buffered redirect.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            value_out            <= RESET_VALUE;
            pend_value_q         <= '0;
            redirect_pending_out <= 1'b0;
            select_error_out     <= 1'b0;
        end else begin
            value_out            <= value_d;
            pend_value_q         <= pend_value_d;
            redirect_pending_out <= pend_d;
            select_error_out     <= err_d;
        end
    end

endmodule

// File: tb/tb_pc_select_reg.sv
// Bench for pc_select_reg: vector tables driven through a scoreboard queue,
// plus reset sequences, against a 4-input and a 3-input instance.
module tb_pc_select_reg;

    localparam int unsigned W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4*W-1:0]   vin4;
    logic [3*W-1:0]   vin3;
    logic [1:0]       sel;
    logic             stall;
    logic             rv;
    logic [W-1:0]     rval;
    logic [W-1:0]     v4, v3;
    logic             p4, p3, e4, e3;

    always #5 clk = ~clk;

    pc_select_reg #(.WIDTH(W), .NUM_IN(4), .SEL_W(2), .RESET_VALUE(32'h0)) dut4 (
        .clock_in(clk), .reset_n_in(rst_n), .value_in(vin4), .select_in(sel),
        .stall_in(stall), .redirect_valid_in(rv), .redirect_value_in(rval),
        .value_out(v4), .redirect_pending_out(p4), .select_error_out(e4)
    );

    pc_select_reg #(.WIDTH(W), .NUM_IN(3), .SEL_W(2), .RESET_VALUE(32'h0)) dut3 (
        .clock_in(clk), .reset_n_in(rst_n), .value_in(vin3), .select_in(sel),
        .stall_in(stall), .redirect_valid_in(rv), .redirect_value_in(rval),
        .value_out(v3), .redirect_pending_out(p3), .select_error_out(e3)
    );

    typedef struct {
        logic         stall;
        logic         rv;
        logic [W-1:0] rval;
        logic [1:0]   sel;
        logic [W-1:0] ev;
        logic         ep;
        logic         ee;
    } vec_t;

    typedef struct {
        logic [W-1:0] ev;
        logic         ep;
        logic         ee;
    } exp_t;

    exp_t sb[$];
    vec_t t4[$];
    vec_t t3[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   which    = 4;

    function automatic vec_t mk(input logic s, input logic r, input logic [W-1:0] rvalue,
                                input logic [1:0] sl, input logic [W-1:0] ev,
                                input logic ep, input logic ee);
        vec_t v;
        v.stall = s; v.rv = r; v.rval = rvalue; v.sel = sl;
        v.ev = ev; v.ep = ep; v.ee = ee;
        return v;
    endfunction

    task automatic check1(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector and queue what the selected instance must show after the edge.
    task automatic drive(input vec_t v);
        exp_t e;
        rst_n = 1'b1;
        stall = v.stall;
        rv    = v.rv;
        rval  = v.rval;
        sel   = v.sel;
        e.ev = v.ev; e.ep = v.ep; e.ee = v.ee;
        sb.push_back(e);
    endtask

    task automatic sample(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            if (which == 4) begin
                check1({tag, ".value"},   v4, e.ev);
                check1({tag, ".pending"}, W'(p4), W'(e.ep));
                check1({tag, ".error"},   W'(e4), W'(e.ee));
            end else begin
                check1({tag, ".value"},   v3, e.ev);
                check1({tag, ".pending"}, W'(p3), W'(e.ep));
                check1({tag, ".error"},   W'(e3), W'(e.ee));
            end
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        sample(tag);
    endtask

    // Assert reset between edges, check it acts at once and holds across an edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0; rv = 1'b0; rval = '0; sel = 2'd0;
        #1;
        check1({tag, ".v4"}, v4, 32'h0);
        check1({tag, ".p4"}, W'(p4), W'(1'b0));
        check1({tag, ".e4"}, W'(e4), W'(1'b0));
        check1({tag, ".v3"}, v3, 32'h0);
        check1({tag, ".p3"}, W'(p3), W'(1'b0));
        check1({tag, ".e3"}, W'(e3), W'(1'b0));
        @(posedge clk);
        #1;
        check1({tag, ".held_v4"}, v4, 32'h0);
        check1({tag, ".held_e3"}, W'(e3), W'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; rv = 1'b0; rval = '0; sel = 2'd0;
        vin4  = {32'h40, 32'h30, 32'h20, 32'h10};
        vin3  = {32'h30, 32'h20, 32'h10};

        // 4-input instance: basic select, stall hold, redirect/pending, X select
        t4.push_back(mk(0, 0, 32'h0,  2'd2,  32'h30, 0, 0));
        t4.push_back(mk(0, 0, 32'h0,  2'd0,  32'h10, 0, 0));
        t4.push_back(mk(0, 0, 32'h0,  2'd2,  32'h30, 0, 0));
        t4.push_back(mk(1, 0, 32'h0,  2'd0,  32'h30, 0, 0));
        t4.push_back(mk(1, 0, 32'h0,  2'd1,  32'h30, 0, 0));
        t4.push_back(mk(1, 0, 32'h0,  2'd3,  32'h30, 0, 0));
        t4.push_back(mk(0, 0, 32'h0,  2'd1,  32'h20, 0, 0));
        t4.push_back(mk(1, 1, 32'hA0, 2'd0,  32'h20, 1, 0));
        t4.push_back(mk(1, 1, 32'hB0, 2'd1,  32'h20, 1, 0));
        t4.push_back(mk(1, 0, 32'h0,  2'd2,  32'h20, 1, 0));
        t4.push_back(mk(0, 0, 32'h0,  2'd3,  32'hB0, 0, 0));
        t4.push_back(mk(0, 0, 32'h0,  2'd0,  32'h10, 0, 0));
        t4.push_back(mk(1, 1, 32'hB0, 2'd3,  32'h10, 1, 0));
        t4.push_back(mk(0, 1, 32'hC0, 2'd2,  32'hC0, 0, 0));
        t4.push_back(mk(0, 0, 32'h0,  2'd2,  32'h30, 0, 0));
        t4.push_back(mk(0, 0, 32'h0,  2'd3,  32'h40, 0, 0));
        t4.push_back(mk(0, 1, 32'hD0, 2'd1,  32'hD0, 0, 0));
        t4.push_back(mk(1, 1, 32'hE0, 2'bxx, 32'hD0, 1, 0));
        t4.push_back(mk(0, 0, 32'h0,  2'bxx, 32'hE0, 0, 0));
        t4.push_back(mk(0, 0, 32'h0,  2'd1,  32'h20, 0, 0));

        // 3-input instance: illegal select only flags outside stall/redirect/drain
        t3.push_back(mk(0, 0, 32'h0,  2'd1, 32'h20, 0, 0));
        t3.push_back(mk(1, 0, 32'h0,  2'd3, 32'h20, 0, 0));
        t3.push_back(mk(0, 1, 32'hA0, 2'd3, 32'hA0, 0, 0));
        t3.push_back(mk(1, 1, 32'hB0, 2'd3, 32'hA0, 1, 0));
        t3.push_back(mk(0, 0, 32'h0,  2'd3, 32'hB0, 0, 0));
        t3.push_back(mk(0, 0, 32'h0,  2'd1, 32'h20, 0, 0));
        t3.push_back(mk(0, 0, 32'h0,  2'd3, 32'h20, 0, 1));
        t3.push_back(mk(0, 0, 32'h0,  2'd0, 32'h10, 0, 1));
        t3.push_back(mk(1, 0, 32'h0,  2'd3, 32'h10, 0, 1));
        t3.push_back(mk(0, 0, 32'h0,  2'd2, 32'h30, 0, 1));

        which = 4;
        do_reset("rst_a");
        foreach (t4[i]) apply(t4[i], $sformatf("t4[%0d]", i));

        // Reset between edges while a redirect is pending: it must be lost.
        apply(mk(1, 1, 32'hF0, 2'd0, 32'h20, 1, 0), "mid_pend");
        #2;
        rst_n = 1'b0;
        #1;
        check1("mid_rst.value",   v4, 32'h0);
        check1("mid_rst.pending", W'(p4), W'(1'b0));
        @(posedge clk);
        #1;
        check1("mid_rst.held", v4, 32'h0);
        apply(mk(0, 0, 32'h0, 2'd0, 32'h10, 0, 0), "mid_release");
        apply(mk(0, 0, 32'h0, 2'd2, 32'h30, 0, 0), "mid_after");

        which = 3;
        do_reset("rst_b");
        foreach (t3[i]) apply(t3[i], $sformatf("t3[%0d]", i));

        // Sticky error is cleared only by reset.
        do_reset("rst_c");
        apply(mk(0, 0, 32'h0, 2'd0, 32'h10, 0, 0), "err_cleared");

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_select_reg.md
Name: pc_select_reg

Overview:
- Parametrised, registered successor to the 32-bit 2:1 branch mux.
- Selects the next-PC value from NUM_IN candidate sources and registers the result. Typical sources are PC+4, branch target, jump target and register target.
- Adds stall hold, a redirect override with a one-deep pending buffer, and sticky detection of an illegal select.
- Sits between the PC-source logic and the PC/fetch stage.

Parameters:
- WIDTH, 32, bit width of each candidate and of the output.
- NUM_IN, 4, number of candidate inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- RESET_VALUE, 32'h0000_0000, value driven on value_out during and after reset (WIDTH bits).

Ports:
- clock_in  input  1  rising-edge clock.
- reset_n_in  input  1  asynchronous active-low reset.
- value_in  input  NUM_IN*WIDTH  packed candidates; candidate k occupies bits [k*WIDTH +: WIDTH].
- select_in  input  SEL_W  index of the candidate to register.
- stall_in  input  1  1 = hold value_out this cycle.
- redirect_valid_in  input  1  1 = override the normal selection with redirect_value_in.
- redirect_value_in  input  WIDTH  redirect target.
- value_out  output  WIDTH  registered selected value.
- redirect_pending_out  output  1  1 = a redirect is buffered and waiting for the stall to release.
- select_error_out  output  1  sticky flag: an out-of-range select was used.

Behaviour:
- Reset (reset_n_in=0, asynchronous, takes effect immediately and is held while low):
  - value_out=RESET_VALUE.
  - redirect_pending_out=0.
  - select_error_out=0.
  - internal pending register=0.
- Reset release: first update occurs on the first rising edge with reset_n_in=1.
- Latency: one cycle. Inputs sampled at edge N appear on value_out after edge N. There is no combinational path from any input to any output.
- Per rising edge, priority highest first:
  1. stall_in=1: value_out holds. If redirect_valid_in=1, capture redirect_value_in into the pending register and set pending=1. A newer redirect overwrites an older pending one (latest wins). select_in is ignored.
  2. stall_in=0, redirect_valid_in=1: value_out<=redirect_value_in; pending<=0, discarding any older pending value.
  3. stall_in=0, pending=1: value_out<=pending register; pending<=0.
  4. stall_in=0, no redirect, no pending, select_in<NUM_IN: value_out<=candidate[select_in].
  5. stall_in=0, no redirect, no pending, select_in>=NUM_IN: value_out holds; select_error_out<=1.
- select_error_out is sticky: cleared only by reset, and evaluated only in case 5. An illegal select during stall, redirect or pending drain does not set it.
- Pending buffer is exactly one entry. Only the most recent redirect seen during a stall survives.
- Reset mid-stall with pending=1: the pending redirect is lost; outputs return to reset values.
- When NUM_IN == 2**SEL_W, case 5 is unreachable and select_error_out stays 0.
- Candidate slicing uses the fixed index k*WIDTH; select_in is treated as unsigned.
- X on select_in in cases 1–3 must not propagate to value_out.

Test Plan:
1. Reset/basic select:
   - Stimulus: assert reset_n_in=0; release; then NUM_IN=4, candidates {0x10,0x20,0x30,0x40}, select_in=2, stall=0.
   - Required: value_out=0x0 while in reset; 0x30 one edge after release; select_in=0 on the next edge -> 0x10 after that edge.
2. Stall hold:
   - Stimulus: value_out=0x30, stall_in=1 for 3 edges, select_in toggling 0..3.
   - Required: value_out stays 0x30 throughout; after stall drops with select_in=1, value_out=0x20 one edge later.
3. Redirect during stall:
   - Stimulus: stall_in=1; redirect 0xA0 at edge 1, redirect 0xB0 at edge 2; stall drops at edge 4 with no redirect.
   - Required: redirect_pending_out=1 from edge 1; value_out held until edge 4; value_out=0xB0 after edge 4; pending=0 after edge 4.
4. Redirect beats pending:
   - Stimulus: pending holds 0xB0; stall drops in the same cycle as redirect_valid_in=1 with value 0xC0.
   - Required: value_out=0xC0; pending cleared; 0xB0 never appears on value_out.
5. Illegal select:
   - Stimulus: WIDTH=32, NUM_IN=3, SEL_W=2, value_out=0x20, select_in=3, stall=0.
   - Required: value_out stays 0x20; select_error_out=1 and remains 1 after select_in returns to 0 (value_out=0x10); cleared only by reset.
6. Asynchronous reset mid-operation:
   - Stimulus: pending=1, stall=1; pull reset_n_in low between clock edges.
   - Required: value_out=RESET_VALUE and redirect_pending_out=0 before the next edge; after release with stall=0 and select_in=0, value_out=0x10, not the lost redirect.
